// File: rtl/branch_comp_if.sv
// Operand/condition bundle and flag outputs of the branch comparator.
// Carries taken_cnt only when BRANCHCOMP_STATS_EN is defined.
interface branch_comp_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       funct;
  logic             valid_in;
  logic             result;
  logic             taken;
  logic             valid_q;
  logic             taken_q;
  logic             eq_q;
  logic             lt_q;
  logic             ltu_q;
  logic             illegal_q;
`ifdef BRANCHCOMP_STATS_EN
  logic [15:0]      taken_cnt;
`endif

  modport master (
    output a, b, funct, valid_in,
    input  result, taken, valid_q, taken_q,
    input  eq_q, lt_q, ltu_q, illegal_q
`ifdef BRANCHCOMP_STATS_EN
    , input taken_cnt
`endif
  );

  modport slave (
    input  a, b, funct, valid_in,
    output result, taken, valid_q, taken_q,
    output eq_q, lt_q, ltu_q, illegal_q
`ifdef BRANCHCOMP_STATS_EN
    , output taken_cnt
`endif
  );
endinterface

// File: rtl/branch_comp.sv
// Branch comparator: eq/lt/ltu resolve, funct-selected taken, registered flags.
// Optional saturating taken counter under BRANCHCOMP_STATS_EN.
module branch_comp #(
  parameter int WIDTH = 1
) (
  input logic        clk,
  input logic        rst_n,
  branch_comp_if.slave bus
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic eq, lt, ltu, tk, ill;

  assign a = bus.a;
  assign b = bus.b;

  always_comb begin
    eq  = (a == b);
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    tk  = 1'b0;
    ill = 1'b0;
    case (bus.funct)
      3'b000:  tk = eq;
      3'b001:  tk = !eq;
      3'b100:  tk = lt;
      3'b101:  tk = !lt;
      3'b110:  tk = ltu;
      3'b111:  tk = !ltu;
      default: ill = 1'b1;
    endcase
  end

  assign bus.result = eq;
  assign bus.taken  = tk;

  logic vld_q, tk_q, eq_q, lt_q, ltu_q, ill_q;

  // Flags hold between captures; only the valid strobe drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      tk_q  <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      ltu_q <= 1'b0;
      ill_q <= 1'b0;
    end else if (bus.valid_in) begin
      vld_q <= 1'b1;
      tk_q  <= tk;
      eq_q  <= eq;
      lt_q  <= lt;
      ltu_q <= ltu;
      ill_q <= ill;
    end else begin
      vld_q <= 1'b0;
    end
  end

  assign bus.valid_q   = vld_q;
  assign bus.taken_q   = tk_q;
  assign bus.eq_q      = eq_q;
  assign bus.lt_q      = lt_q;
  assign bus.ltu_q     = ltu_q;
  assign bus.illegal_q = ill_q;

`ifdef BRANCHCOMP_STATS_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.valid_in && tk && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

  assign bus.taken_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_branch_comp.sv
// Bench for branch_comp: WIDTH=1 and WIDTH=8 instances checked
// against an arithmetic reference model with directed and random steps.
module tb_branch_comp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  branch_comp_if #(.WIDTH(1)) if1();
  branch_comp_if #(.WIDTH(8)) if8();

  branch_comp #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  branch_comp #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  // model state, index 0 = WIDTH 1, index 1 = WIDTH 8
  bit          m_v[2], m_tk[2], m_eq[2], m_lt[2], m_ltu[2], m_ill[2];
  logic [15:0] m_cnt[2];

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_eval(input int w, input logic [7:0] a8, b8,
                          input logic [2:0] f,
                          output bit eq, lt, ltu, tk, ill);
    int ua, ub, sa, sb;
    ua = int'(a8) % (1 << w);
    ub = int'(b8) % (1 << w);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    eq  = (ua == ub);
    lt  = (sa < sb);
    ltu = (ua < ub);
    ill = (f == 3'd2) || (f == 3'd3);
    case (f)
      3'd0: tk = eq;
      3'd1: tk = !eq;
      3'd4: tk = lt;
      3'd5: tk = !lt;
      3'd6: tk = ltu;
      3'd7: tk = !ltu;
      default: tk = 1'b0;
    endcase
  endtask

  task automatic step(input logic [7:0] a8, b8, input logic [2:0] f,
                      input logic v, input logic r);
    bit eq, lt, ltu, tk, ill;
    logic [5:0] got, exp;
    string pfx;
    @(negedge clk);
    rst_n = r;
    if1.a = a8[0]; if1.b = b8[0]; if1.funct = f; if1.valid_in = v;
    if8.a = a8;    if8.b = b8;    if8.funct = f; if8.valid_in = v;
    #1;
    for (int w = 0; w < 2; w++) begin
      pfx = (w == 0) ? "w1" : "w8";
      ref_eval((w == 0) ? 1 : 8, a8, b8, f, eq, lt, ltu, tk, ill);
      chk({pfx, ".result"}, 16'((w == 0) ? if1.result : if8.result), 16'(eq));
      chk({pfx, ".taken"}, 16'((w == 0) ? if1.taken : if8.taken), 16'(tk));
      if (!r) begin
        m_v[w] = 0; m_tk[w] = 0; m_eq[w] = 0;
        m_lt[w] = 0; m_ltu[w] = 0; m_ill[w] = 0; m_cnt[w] = 0;
      end else if (v) begin
        m_v[w] = 1; m_tk[w] = tk; m_eq[w] = eq;
        m_lt[w] = lt; m_ltu[w] = ltu; m_ill[w] = ill;
        if (tk && m_cnt[w] != 16'hFFFF) m_cnt[w] = m_cnt[w] + 1;
      end else begin
        m_v[w] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      pfx = (w == 0) ? "w1" : "w8";
      got = (w == 0) ?
        {if1.valid_q, if1.taken_q, if1.eq_q, if1.lt_q, if1.ltu_q, if1.illegal_q} :
        {if8.valid_q, if8.taken_q, if8.eq_q, if8.lt_q, if8.ltu_q, if8.illegal_q};
      exp = {m_v[w], m_tk[w], m_eq[w], m_lt[w], m_ltu[w], m_ill[w]};
      chk({pfx, ".regs{v,tk,eq,lt,ltu,ill}"}, 16'(got), 16'(exp));
`ifdef BRANCHCOMP_STATS_EN
      chk({pfx, ".taken_cnt"},
          (w == 0) ? if1.taken_cnt : if8.taken_cnt, m_cnt[w]);
`endif
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    if1.a = '0; if1.b = '0; if1.funct = '0; if1.valid_in = 1'b0;
    if8.a = '0; if8.b = '0; if8.funct = '0; if8.valid_in = 1'b0;
    for (int w = 0; w < 2; w++) m_cnt[w] = '0;

    // reset with valid_in high: capture discarded, result still live
    step(8'h33, 8'h33, 3'd0, 1'b1, 1'b0);
    step(8'h12, 8'h34, 3'd1, 1'b1, 1'b0);
    chk("rst.w8.valid_q", 16'(if8.valid_q), 16'd0);

    // signed vs unsigned: 0x80 < 0x01 signed only
    step(8'h80, 8'h01, 3'd4, 1'b1, 1'b1);
    chk("flags.w8.lt_q", 16'(if8.lt_q), 16'd1);
    chk("flags.w8.ltu_q", 16'(if8.ltu_q), 16'd0);
    // reserved code
    step(8'h5A, 8'h5A, 3'd3, 1'b1, 1'b1);
    chk("resv.w8.illegal_q", 16'(if8.illegal_q), 16'd1);
    // w1 signed view: a=1 is -1
    step(8'h01, 8'h00, 3'd4, 1'b1, 1'b1);
    chk("w1.lt_q", 16'(if1.lt_q), 16'd1);
    chk("w1.ltu_q", 16'(if1.ltu_q), 16'd0);
    // hold flags with valid_in low
    step(8'h00, 8'hFF, 3'd0, 1'b0, 1'b1);
    // back-to-back captures: 3 taken, 2 not taken
    step(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    step(8'h01, 8'h01, 3'd0, 1'b1, 1'b1);
    step(8'h02, 8'h01, 3'd1, 1'b1, 1'b1);
    step(8'h03, 8'h07, 3'd6, 1'b1, 1'b1);
    step(8'h03, 8'h07, 3'd7, 1'b1, 1'b1);
    step(8'hFF, 8'h00, 3'd5, 1'b1, 1'b1);
    chk("b2b.w8.valid_q", 16'(if8.valid_q), 16'd1);
    // reset mid-operation
    step(8'h10, 8'h10, 3'd0, 1'b1, 1'b0);
    step(8'h10, 8'h10, 3'd0, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      step(ra, rb, 3'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) != 0));
    end

    @(negedge clk);
    if1.valid_in = 1'b0;
    if8.valid_in = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if1.a = 1'(p >> 1);
      if1.b = 1'(p);
      #10;
      chk($sformatf("w1.exh%0d%0d", p >> 1, p & 1), 16'(if1.result),
          16'((p >> 1) == (p & 1)));
    end
    for (int i = 0; i < 100; i++) begin
      if1.a = 1'($urandom);
      if1.b = 1'($urandom);
      #10;
      chk("w1.rand_result", 16'(if1.result), 16'(if1.a == if1.b));
    end

    if (n_bad == 0) $display("PASS");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
